alu_logic_stage: RTL and testbench
==================================

Name: alu_logic_stage

Overview:
- Parametrised, registered successor to the 32-bit ALU result select mux.
- Accepts one operation per beat: operands a, b, pass-through value c, and an opcode.
- Computes a logic result plus zero and op-error flags and holds them in a 2-entry output skid buffer with valid/ready handshakes on both sides.
- Sits between the MCU ALU arithmetic path (which supplies c) and the writeback stage.

Parameters:
- WIDTH, 32, data width of a, b, c, y (≥ 2).
- SHAMT_W, $clog2(WIDTH), shift-amount width; used only with ALU_SHIFT_EN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- op  input  3  operation select
- a  input  WIDTH  operand a
- b  input  WIDTH  operand b
- c  input  WIDTH  pass-through value
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head entry
- y  output  WIDTH  head entry result
- zero  output  1  head entry result == 0
- op_err  output  1  head entry used reserved opcode

Behaviour:
- Single clock domain, clk.
- Reset is asynchronous and active-low (rst_n).
- While rst_n = 0:
  - count = 0, out_valid = 0, in_ready = 0.
  - y = 0, zero = 0, op_err = 0.
  - Both buffer entries are cleared.
- in_ready goes to 1 on the first clk edge after rst_n deasserts.
- Reset mid-operation discards all buffered entries with no output beat.
- Opcode map (combinational on input beat):
  - 000 → c
  - 001 → c (legacy alias)
  - 010 → a & b
  - 011 → a | b
  - 100 → a ^ b
  - 101 → ~(a | b)
  - 110 → ~(a & b)
  - 111 → reserved: result c, op_err = 1
- zero = (result == 0), computed at capture and stored with the entry.
- Handshakes:
  - Push when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - Inputs are sampled only on push.
  - y/zero/op_err are stable while out_valid = 1 and out_ready = 0.
- Buffer state by count:
  - EMPTY (0): in_ready = 1, out_valid = 0.
  - ONE (1): in_ready = 1, out_valid = 1.
  - FULL (2): in_ready = 0, out_valid = 1.
- in_ready is registered, derived from the next-state count only; it has no combinational path from out_ready.
- Transitions:
  - EMPTY + push → ONE.
  - ONE + push, no pop → FULL.
  - ONE + pop, no push → EMPTY.
  - ONE + push + pop → ONE; the new entry becomes head on the next cycle.
  - FULL + pop → ONE; the second entry moves to head.
  - FULL never pushes.
- Latency: a push into EMPTY presents on y the next cycle (1-cycle latency).
- Throughput: 1 beat/cycle when out_ready is held high.
- Ordering: strict FIFO; no beat dropped or duplicated.
- X on a, b, c while in_valid = 0 must not propagate to the outputs.

Optional Feature:
- Macro ALU_SHIFT_EN.
- Defined:
  - op 111 = logical left shift: a << b[SHAMT_W-1:0].
  - op_err = 0 for all opcodes.
  - zero follows the shifted result.
- Undefined:
  - op 111 is reserved as above: result c, op_err = 1.
  - The shifter is not synthesised.

Test Plan:
- Reset/first beat: rst_n low 3 cycles, then release. Expect out_valid = 0, y = 0; in_ready = 1 one cycle after release. Push op=010, a=0xF0F0_00FF, b=0x0FF0_FF0F, out_ready=1 → next cycle y=0x00F0_000F, zero=0, out_valid=1.
- Full opcode sweep with a=0xAAAA_5555, b=0xFFFF_0000, c=0x1234_5678, one push per op (000..110):
  - 000 and 001 → 0x1234_5678.
  - 010 → 0xAAAA_0000.
  - 011 → 0xFFFF_5555.
  - 100 → 0x5555_5555.
  - 101 → 0x0000_AAAA.
  - 110 → 0x5555_FFFF.
  - 010 with b=0 → zero=1.
- Backpressure: out_ready=0, push 3 consecutive beats. Beats 1 and 2 accepted, in_ready=0 from the cycle after the second push, beat 3 held upstream. Raise out_ready → order 1, 2, 3 preserved; y holds each value while stalled.
- Simultaneous push/pop in ONE state for 8 cycles with out_ready=1 → count stays 1, 8 results in order, in_ready never drops.
- Reserved/shift: op=111, a=0x1, b=0x4, c=0xDEAD_BEEF.
  - Without ALU_SHIFT_EN → y=0xDEAD_BEEF, op_err=1.
  - With ALU_SHIFT_EN → y=0x10, op_err=0.
- Reset mid-operation: FULL with out_ready=0, pulse rst_n low asynchronously between edges → out_valid drops immediately, y=0; after release no stale beat appears.

Source files
------------

// File: rtl/alu_logic_stage.sv
// alu_logic_stage
// Registered logic-result stage placed after the MCU ALU arithmetic path.
// Each accepted beat produces a logic result from a/b, or passes c through.
// The result is stored with a zero flag and an op-error flag in a 2-entry
// skid buffer. Both sides use valid/ready handshakes.
//
// Optional feature (macro ALU_SHIFT_EN):
//   defined   : op 111 = a << b[SHAMT_W-1:0], and op_err is never set
//   undefined : op 111 is reserved (result c, op_err = 1), no shifter is built
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    upstream handshake (in_ready is registered)
//   op, a, b, c          operation select, operands, pass-through value
//   out_valid/out_ready  downstream handshake for the head entry
//   y, zero, op_err      head entry result and flags (registered)
module alu_logic_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             op_err
);

    // Opcode encodings
    localparam logic [2:0] OP_PASS  = 3'b000;
    localparam logic [2:0] OP_ALIAS = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOR   = 3'b101;
    localparam logic [2:0] OP_NAND  = 3'b110;
    localparam logic [2:0] OP_EXT   = 3'b111;

    // Elaboration-time sanity check on the parameters
    if (WIDTH < 2 || (64'(1) << SHAMT_W) < 64'(WIDTH)) begin : g_param_check
        $error("alu_logic_stage: WIDTH must be >= 2 and SHAMT_W wide enough to index WIDTH");
    end

    // Buffer occupancy
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Tail (second) entry storage; the head entry is the y/zero/op_err flops
    logic [WIDTH-1:0] tail_y_q;
    logic             tail_zero_q;
    logic             tail_err_q;

    // Result of the beat currently presented on the input
    logic [WIDTH-1:0] res_c;
    logic             res_err_c;
    logic             res_zero_c;

    // Handshake events
    logic push_c;
    logic pop_c;

    // Entry movement controls
    logic head_load_new_c;
    logic head_load_tail_c;
    logic tail_load_new_c;

    assign push_c = in_valid & in_ready;
    assign pop_c  = out_valid & out_ready;

    // Opcode decode and logic function
    always_comb begin
        res_c     = c;
        res_err_c = 1'b0;
        unique case (op)
            OP_PASS:  res_c = c;
            OP_ALIAS: res_c = c;
            OP_AND:   res_c = a & b;
            OP_OR:    res_c = a | b;
            OP_XOR:   res_c = a ^ b;
            OP_NOR:   res_c = ~(a | b);
            OP_NAND:  res_c = ~(a & b);
            OP_EXT: begin
`ifdef ALU_SHIFT_EN
                res_c     = a << b[SHAMT_W-1:0];
                res_err_c = 1'b0;
`else
                res_c     = c;
                res_err_c = 1'b1;
`endif
            end
            default: begin
                res_c     = c;
                res_err_c = 1'b0;
            end
        endcase
    end

    assign res_zero_c = (res_c == '0);

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and entry movement
    always_comb begin
        state_d          = state_q;
        head_load_new_c  = 1'b0;
        head_load_tail_c = 1'b0;
        tail_load_new_c  = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (push_c) begin
                    state_d         = ONE;
                    head_load_new_c = 1'b1;
                end
            end
            ONE: begin
                unique case ({push_c, pop_c})
                    2'b10: begin
                        state_d         = FULL;
                        tail_load_new_c = 1'b1;
                    end
                    2'b01: begin
                        state_d = EMPTY;
                    end
                    2'b11: begin
                        // Head leaves and the new beat replaces it directly
                        state_d         = ONE;
                        head_load_new_c = 1'b1;
                    end
                    default: begin
                        state_d = ONE;
                    end
                endcase
            end
            FULL: begin
                // in_ready is low here, so only a pop can happen
                if (pop_c) begin
                    state_d          = ONE;
                    head_load_tail_c = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Handshake flags follow the next occupancy, so in_ready has no path from out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_d != FULL);
            out_valid <= (state_d != EMPTY);
        end
    end

    // Head entry; held unchanged while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y      <= '0;
            zero   <= 1'b0;
            op_err <= 1'b0;
        end else if (head_load_new_c) begin
            y      <= res_c;
            zero   <= res_zero_c;
            op_err <= res_err_c;
        end else if (head_load_tail_c) begin
            y      <= tail_y_q;
            zero   <= tail_zero_q;
            op_err <= tail_err_q;
        end
    end

    // Tail entry; only written when the head is occupied and not popping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail_y_q    <= '0;
            tail_zero_q <= 1'b0;
            tail_err_q  <= 1'b0;
        end else if (tail_load_new_c) begin
            tail_y_q    <= res_c;
            tail_zero_q <= res_zero_c;
            tail_err_q  <= res_err_c;
        end
    end

endmodule

// File: tb/tb_alu_logic_stage.sv
// Directed testbench for alu_logic_stage. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_alu_logic_stage;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             op_err;

    int checks = 0;
    int errors = 0;

    alu_logic_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .op_err    (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        in_valid = 1'b0;
        op       = 3'b000;
        a        = 'x;
        b        = 'x;
        c        = 'x;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || y !== 32'h0 || zero !== 1'b0 || op_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b y=%h zero=%b op_err=%b, required 0 0 00000000 0 0",
                     out_valid, in_ready, y, zero, op_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        in_valid = 1'b1;
        op       = 3'b010;
        a        = 32'hF0F0_00FF;
        b        = 32'h0FF0_FF0F;
        c        = 32'h0;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (out_valid !== 1'b1 || y !== 32'h00F0_000F || zero !== 1'b0 || op_err !== 1'b0) begin
            errors++;
            $display("FAIL first_beat: out_valid=%b y=%h zero=%b op_err=%b, required 1 00f0000f 0 0",
                     out_valid, y, zero, op_err);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_beat_pop: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_opcodes();
        logic [2:0]  ops  [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b010};
        logic [31:0] bs   [8] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                  32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_0000};
        logic [31:0] exps [8] = '{32'h1234_5678, 32'h1234_5678, 32'hAAAA_0000, 32'hFFFF_5555,
                                  32'h5555_5555, 32'h0000_AAAA, 32'h5555_FFFF, 32'h0000_0000};
        logic        zexp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            op       = ops[i];
            a        = 32'hAAAA_5555;
            b        = bs[i];
            c        = 32'h1234_5678;
            @(negedge clk);
            idle_inputs();
            checks++;
            if (out_valid !== 1'b1 || y !== exps[i] || zero !== zexp[i] || op_err !== 1'b0) begin
                errors++;
                $display("FAIL opcode_%0d_op%b: out_valid=%b y=%h zero=%b op_err=%b, required 1 %h %b 0",
                         i, ops[i], out_valid, y, zero, op_err, exps[i], zexp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'b000;
        c         = 32'h1111_0001;
        @(negedge clk);
        c = 32'h2222_0002;
        @(negedge clk);
        c = 32'h3333_0003;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 32'h1111_0001) begin
                errors++;
                $display("FAIL backpressure_stall_%0d: in_ready=%b out_valid=%b y=%h, required 0 1 11110001",
                         i, in_ready, out_valid, y);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (y !== 32'h2222_0002 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_order2: y=%h out_valid=%b in_ready=%b, required 22220002 1 1",
                     y, out_valid, in_ready);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (y !== 32'h3333_0003 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_order3: y=%h out_valid=%b, required 33330003 1", y, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_drain: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                checks++;
                if (y !== 32'hB0B0_0000 + 32'(i - 1) || out_valid !== 1'b1 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL back_to_back_%0d: y=%h out_valid=%b in_ready=%b, required %h 1 1",
                             i - 1, y, out_valid, in_ready, 32'hB0B0_0000 + 32'(i - 1));
                end
            end
            if (i < 8) begin
                in_valid = 1'b1;
                op       = 3'b001;
                c        = 32'hB0B0_0000 + 32'(i);
            end else begin
                idle_inputs();
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_drain: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reserved();
        logic [31:0] exp_y;
        logic        exp_err;
`ifdef ALU_SHIFT_EN
        exp_y   = 32'h0000_0010;
        exp_err = 1'b0;
`else
        exp_y   = 32'hDEAD_BEEF;
        exp_err = 1'b1;
`endif
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 3'b111;
        a         = 32'h1;
        b         = 32'h4;
        c         = 32'hDEAD_BEEF;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (out_valid !== 1'b1 || y !== exp_y || op_err !== exp_err || zero !== 1'b0) begin
            errors++;
            $display("FAIL reserved_op: out_valid=%b y=%h op_err=%b zero=%b, required 1 %h %b 0",
                     out_valid, y, op_err, zero, exp_y, exp_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'b000;
        c         = 32'h5A5A_0001;
        @(negedge clk);
        c = 32'h5A5A_0002;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_full: out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== 32'h0 || in_ready !== 1'b0 || op_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: out_valid=%b y=%h in_ready=%b op_err=%b, required 0 00000000 0 0",
                     out_valid, y, in_ready, op_err);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || y !== 32'h0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_stale_%0d: out_valid=%b y=%h in_ready=%b, required 0 00000000 1",
                         i, out_valid, y, in_ready);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_opcodes();
        test_backpressure();
        test_back_to_back();
        test_reserved();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound on total run time in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
